// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin front end for one single-port synchronous RAM.
// Read data returns to the issuing requester through a registered per-lane stage.

module ram_rr_lane #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [data_width-1:0] q,
  output logic [data_width-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (load) rdata <= q;
  end
endmodule

module ram_rr_arbiter #(
  parameter int addr_width = 6,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [addr_width-1:0] addr_a,
  input  logic [data_width-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [data_width-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [addr_width-1:0] addr_b,
  input  logic [data_width-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [data_width-1:0] rdata_b,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data,
  input  logic [data_width-1:0] ram_q
);
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
  } cmd_t;

  cmd_t [NUM_LANES-1:0]                 cmd;
  cmd_t                                 win;
  logic [NUM_LANES-1:0]                 req, gnt, load, rvalid;
  logic [NUM_LANES-1:0][data_width-1:0] rdata;
  logic                                 last_b;
  logic                                 rd_issue;
  logic [STAGES:0]                      vld_pipe, own_pipe;

  assign req    = {req_b, req_a};
  assign cmd[0] = {we_a, addr_a, wdata_a};
  assign cmd[1] = {we_b, addr_b, wdata_b};

  // Contention goes to whoever did not win last; reset leaves B as last so A leads.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (&req) gnt = last_b ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (gnt[i]) win = cmd[i];
  end

  assign gnt_a    = gnt[0];
  assign gnt_b    = gnt[1];
  assign ram_we   = win.we;
  assign ram_addr = win.addr;
  assign ram_data = win.wdata;
  assign rd_issue = (|gnt) & ~win.we;

  // vld_pipe[0]: tag alongside ram_q (N+1); vld_pipe[1]: response visible (N+2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b   <= 1'b1;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      if (|gnt) last_b <= gnt[1];
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      own_pipe <= {own_pipe[STAGES-1:0], gnt[1]};
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign load[g]   = vld_pipe[0] & (own_pipe[0] == 1'(g));
    assign rvalid[g] = vld_pipe[1] & (own_pipe[1] == 1'(g));
    ram_rr_lane #(.data_width(data_width)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .q     (ram_q),
      .rdata (rdata[g])
    );
  end

  assign rvalid_a = rvalid[0];
  assign rvalid_b = rvalid[1];
  assign rdata_a  = rdata[0];
  assign rdata_b  = rdata[1];
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Randomized + directed bench for ram_rr_arbiter: shadow-memory model predicts
// grants and read results; a negedge monitor compares against a response scoreboard.

module tb_ram_rr_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;

  typedef struct { bit req; bit we; bit [AW-1:0] addr; bit [DW-1:0] data; } cmd_t;
  typedef struct { int due; bit [DW-1:0] data; } rsp_t;

  cmd_t ca[$], cb[$];
  rsp_t qa[$], qb[$];
  logic [DW-1:0] mem[2**AW];
  logic [DW-1:0] shadow[2**AW];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ram_rr_arbiter #(.addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 59 + 17);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Single-port RAM environment: write-or-read, q holds during writes.
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] = ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end

  // Reference model and monitor.
  initial begin
    bit            lg_b, ea, eb, ga, gb, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, exp_ra, exp_rb;
    rsp_t          r;
    lg_b = 1'b1; exp_ra = '0; exp_rb = '0;
    for (int i = 0; i < 2**AW; i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctl", {gnt_a, gnt_b, ram_we, rvalid_a, rvalid_b}, '0);
        chk("reset_rdata", {rdata_a, rdata_b}, '0);
        chk("reset_ram", {ram_addr, ram_data}, '0);
        qa.delete(); qb.delete();
        lg_b = 1'b1; exp_ra = '0; exp_rb = '0;
      end else begin
        ea = (qa.size() > 0) && (qa[0].due == cyc);
        eb = (qb.size() > 0) && (qb[0].due == cyc);
        chk("rvalid_a", rvalid_a, ea);
        chk("rvalid_b", rvalid_b, eb);
        if (ea) begin exp_ra = qa[0].data; void'(qa.pop_front()); end
        if (eb) begin exp_rb = qb[0].data; void'(qb.pop_front()); end
        chk("rdata_a", rdata_a, exp_ra);
        chk("rdata_b", rdata_b, exp_rb);
        if (req_a && req_b) begin ga = lg_b; gb = !lg_b; end
        else begin ga = req_a; gb = req_b; end
        chk("grant", {gnt_a, gnt_b}, {ga, gb});
        if (ga)      begin w = we_a; ad = addr_a; d = wdata_a; end
        else if (gb) begin w = we_b; ad = addr_b; d = wdata_b; end
        else         begin w = 1'b0; ad = '0; d = '0; end
        chk("ram_cmd", {ram_we, ram_addr, ram_data}, {w, ad, d});
        if (ga || gb) begin
          lg_b = gb;
          if (w) shadow[ad] = d;
          else begin
            r.due = cyc + 2; r.data = shadow[ad];
            if (ga) qa.push_back(r); else qb.push_back(r);
          end
        end
      end
    end
  end

  // Per-port command driver: holds req until granted; idle entries take one cycle.
  initial begin
    bit sa, sb, pa, pb;
    pa = 0; pb = 0;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    forever begin
      @(negedge clk); sa = gnt_a; sb = gnt_b;
      @(posedge clk); #1;
      if (pa && (!ca[0].req || sa)) void'(ca.pop_front());
      if (pb && (!cb[0].req || sb)) void'(cb.pop_front());
      pa = ca.size() > 0;
      pb = cb.size() > 0;
      req_a = pa && ca[0].req;
      if (pa) begin we_a = ca[0].we; addr_a = ca[0].addr; wdata_a = ca[0].data; end
      req_b = pb && cb[0].req;
      if (pb) begin we_b = cb[0].we; addr_b = cb[0].addr; wdata_b = cb[0].data; end
    end
  end

  function automatic cmd_t mk(input bit req, input bit we, input int a, input int d);
    cmd_t c;
    c.req = req; c.we = we; c.addr = AW'(a); c.data = DW'(d);
    return c;
  endfunction

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!(ca.size() == 0 && cb.size() == 0 && !req_a && !req_b) && n < lim) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (n >= lim) begin
      n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", lim);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset with both requesters already asking.
    ca.push_back(mk(1, 1, 5, 8'h3C));
    ca.push_back(mk(1, 0, 5, 0));
    cb.push_back(mk(1, 1, 6'h30, 8'h77));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(50);

    // Contended back-to-back reads alternate.
    ca.push_back(mk(1, 1, 1, 8'h11));
    cb.push_back(mk(1, 1, 2, 8'h22));
    wait_idle(50);
    for (int i = 0; i < 6; i++) begin
      ca.push_back(mk(1, 0, 1, 0));
      cb.push_back(mk(1, 0, 2, 0));
    end
    wait_idle(100);

    // A streams alone, then B joins.
    for (int i = 0; i < 6; i++) ca.push_back(mk(1, 0, 3, 0));
    for (int i = 0; i < 3; i++) cb.push_back(mk(0, 0, 0, 0));
    cb.push_back(mk(1, 0, 4, 0));
    wait_idle(100);

    // Write from A visible to B's read on the very next cycle.
    ca.push_back(mk(1, 1, 6'h10, 8'hAA));
    cb.push_back(mk(0, 0, 0, 0));
    cb.push_back(mk(1, 0, 6'h10, 0));
    wait_idle(50);

    // Reset while a read is in flight.
    ca.push_back(mk(1, 0, 7, 0));
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_a && n < 20);
    chk("gnt_before_reset", gnt_a, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Randomized mix, narrow address range to force write/read collisions.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) ca.push_back(mk(0, 0, 0, 0));
      else ca.push_back(mk(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) cb.push_back(mk(0, 0, 0, 0));
      else cb.push_back(mk(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255)));
    end
    wait_idle(3000);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
